// File: rtl/sb_io_ddr_pad.sv
// rtl/sb_io_ddr_pad.sv - bidirectional I/O pad cell with DDR/registered/combinational output paths
// Optional feature macro: IO_PULLUP_EN (weak pull-up on the undriven pad)
module sb_io_ddr_pad #(
  parameter logic [5:0] PIN_TYPE    = 6'b010000,
  parameter             IO_STANDARD = "SB_LVCMOS"
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clock_enable,
  input  logic output_enable,
  input  logic d_out_0,
  input  logic d_out_1,
  inout  wire  package_pin,
  output logic d_in_0,
  output logic d_in_1
);

  localparam logic [1:0] OUT_DDR     = 2'b00;
  localparam logic [1:0] OUT_REG     = 2'b01;
  localparam logic [1:0] OUT_COMB    = 2'b10;
  localparam logic [1:0] OUT_REG_INV = 2'b11;

  localparam logic [1:0] OE_NEVER  = 2'b00;
  localparam logic [1:0] OE_ALWAYS = 2'b01;
  localparam logic [1:0] OE_COMB   = 2'b10;
  localparam logic [1:0] OE_REG    = 2'b11;

  localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
  localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];
  // Any non-zero input mode selects the combinational pin path for d_in_0.
  localparam logic       IN_COMB  = |PIN_TYPE[1:0];

  // The I/O standard is a label for the pad ring; it has no behavioural effect.
  if ($bits(IO_STANDARD) == 0) begin : g_no_io_standard
  end

  logic q0;
  logic q1;
  logic oe_q;
  logic i0;
  logic i1;
  logic out_bit;
  logic drive;

  // Rising-edge pad registers: output data, registered enable, input sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0   <= 1'b0;
      oe_q <= 1'b0;
      i0   <= 1'b0;
    end else if (clock_enable) begin
      q0   <= d_out_0;
      oe_q <= output_enable;
      i0   <= package_pin;
    end
  end

  // Falling-edge pad registers: second DDR output bit and falling-edge input sample.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      i1 <= 1'b0;
    end else if (clock_enable) begin
      q1 <= d_out_1;
      i1 <= package_pin;
    end
  end

  // Output data select; DDR emits q0 in the high phase and q1 in the low phase.
  always_comb begin
    out_bit = 1'b0;
    case (OUT_MODE)
      OUT_DDR:     out_bit = clk ? q0 : q1;
      OUT_REG:     out_bit = q0;
      OUT_COMB:    out_bit = d_out_0;
      OUT_REG_INV: out_bit = ~q0;
      default:     out_bit = 1'b0;
    endcase
  end

  // Drive enable select.
  always_comb begin
    drive = 1'b0;
    case (OE_MODE)
      OE_NEVER:  drive = 1'b0;
      OE_ALWAYS: drive = 1'b1;
      OE_COMB:   drive = output_enable;
      OE_REG:    drive = oe_q;
      default:   drive = 1'b0;
    endcase
  end

  assign package_pin = drive ? out_bit : 1'bz;

`ifdef IO_PULLUP_EN
  // A floating pad settles weakly high so the input paths read 1.
  pullup (package_pin);
`else
  // No pull device: a floating pad stays at z and the input paths see it as such.
`endif

  assign d_in_0 = IN_COMB ? package_pin : i0;
  assign d_in_1 = i1;

endmodule

// File: tb/tb_sb_io_ddr_pad.sv
// tb/tb_sb_io_ddr_pad.sv - directed self-checking bench for sb_io_ddr_pad
module tb_sb_io_ddr_pad;

  logic clk;
  logic rst_n;
  logic ce;
  logic oe;
  logic d0;
  logic d1;
  logic ext_tri_en;
  logic ext_in_val;

  wire  pin_ddr, pin_tri, pin_inv, pin_in, pin_comb;
  logic ddr_i0, ddr_i1, tri_i0, tri_i1, inv_i0, inv_i1, in_i0, in_i1, comb_i0, comb_i1;

  int checks = 0;
  int errors = 0;

  // DDR output, always driven, registered inputs.
  sb_io_ddr_pad #(.PIN_TYPE(6'b010000)) u_ddr (
    .clk(clk), .rst_n(rst_n), .clock_enable(ce), .output_enable(oe),
    .d_out_0(d0), .d_out_1(d1), .package_pin(pin_ddr), .d_in_0(ddr_i0), .d_in_1(ddr_i1));

  // Registered output, registered output enable.
  sb_io_ddr_pad #(.PIN_TYPE(6'b110100)) u_tri (
    .clk(clk), .rst_n(rst_n), .clock_enable(ce), .output_enable(oe),
    .d_out_0(d0), .d_out_1(d1), .package_pin(pin_tri), .d_in_0(tri_i0), .d_in_1(tri_i1));

  // Registered inverted output, always driven.
  sb_io_ddr_pad #(.PIN_TYPE(6'b011100)) u_inv (
    .clk(clk), .rst_n(rst_n), .clock_enable(ce), .output_enable(oe),
    .d_out_0(d0), .d_out_1(d1), .package_pin(pin_inv), .d_in_0(inv_i0), .d_in_1(inv_i1));

  // Input only, registered inputs.
  sb_io_ddr_pad #(.PIN_TYPE(6'b000000)) u_in (
    .clk(clk), .rst_n(rst_n), .clock_enable(ce), .output_enable(oe),
    .d_out_0(d0), .d_out_1(d1), .package_pin(pin_in), .d_in_0(in_i0), .d_in_1(in_i1));

  // Combinational output, combinational input.
  sb_io_ddr_pad #(.PIN_TYPE(6'b011001)) u_comb (
    .clk(clk), .rst_n(rst_n), .clock_enable(ce), .output_enable(oe),
    .d_out_0(d0), .d_out_1(d1), .package_pin(pin_comb), .d_in_0(comb_i0), .d_in_1(comb_i1));

  // External drivers: the tristate pad is pulled to 0 by the bench while it should be released.
  assign pin_tri = ext_tri_en ? 1'b0 : 1'bz;
  assign pin_in  = ext_in_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One DDR clock: inputs set at fall+2, checked mid high phase and just after the fall.
  task automatic ddr_cycle(input string tag, input logic b0, input logic b1,
                           input logic exp_hi, input logic exp_lo);
    d0 = b0;
    d1 = b1;
    @(posedge clk); #2;
    check_bit({tag, "_hi"}, pin_ddr, exp_hi);
    @(negedge clk); #1;
    check_bit({tag, "_lo"}, pin_ddr, exp_lo);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ce = 1'b1; oe = 1'b0; d0 = 1'b1; d1 = 1'b0;
    ext_tri_en = 1'b1; ext_in_val = 1'b1;

    // Reset state
    @(posedge clk); #2;
    check_bit("rst_ddr_hi", pin_ddr, 1'b0);
    check_bit("rst_inv", pin_inv, 1'b1);
    check_bit("rst_tri_released", pin_tri, 1'b0);
    check_bit("rst_in_d0", in_i0, 1'b0);
    check_bit("rst_in_d1", in_i1, 1'b0);
    @(negedge clk); #1;
    check_bit("rst_ddr_lo", pin_ddr, 1'b0);
    check_bit("rst_in_d1_neg", in_i1, 1'b0);
    #1 rst_n = 1'b1;

    // First enabled edges after release: DDR (1,0) and input sampling of a driven-high pin
    @(posedge clk); #2;
    check_bit("t1_hi0", pin_ddr, 1'b1);
    check_bit("t6_in_d0", in_i0, 1'b1);
    check_bit("t6_in_d1_pre", in_i1, 1'b0);
    @(negedge clk); #1;
    check_bit("t1_lo0", pin_ddr, 1'b0);
    check_bit("t6_in_d1", in_i1, 1'b1);
    #1;
    ddr_cycle("t1_c1", 1'b1, 1'b0, 1'b1, 1'b0);
    ddr_cycle("t1_c2", 1'b1, 1'b0, 1'b1, 1'b0);

    // DDR stream 1,1,0,1,1,0
    ddr_cycle("t2_a", 1'b1, 1'b1, 1'b1, 1'b1);
    ddr_cycle("t2_b", 1'b0, 1'b1, 1'b0, 1'b1);
    ddr_cycle("t2_c", 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid high phase
    d0 = 1'b1; d1 = 1'b1;
    @(posedge clk); #2;
    check_bit("t3_pre", pin_ddr, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("t3_rst_hi", pin_ddr, 1'b0);
    @(negedge clk); #1;
    check_bit("t3_rst_lo", pin_ddr, 1'b0);
    #1;
    rst_n = 1'b1;
    ddr_cycle("t3_post", 1'b0, 1'b1, 1'b0, 1'b1);

    // Clock enable low: DDR keeps toggling between frozen q0=1 and q1=0
    ddr_cycle("ce_load", 1'b1, 1'b0, 1'b1, 1'b0);
    ce = 1'b0;
    ddr_cycle("ce_hold", 1'b0, 1'b1, 1'b1, 1'b0);
    ce = 1'b1;

    // Registered inverted output: one clock latency, hold with clock enable low
    d0 = 1'b0;
    @(posedge clk); #2;
    check_bit("t5_inv_zero", pin_inv, 1'b1);
    @(negedge clk); #2;
    d0 = 1'b1;
    #1;
    check_bit("t5_inv_before_edge", pin_inv, 1'b1);
    @(posedge clk); #2;
    check_bit("t5_inv_one", pin_inv, 1'b0);
    @(negedge clk); #2;
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d0 = ~d0;
      @(posedge clk); #2;
      check_bit("t5_inv_hold", pin_inv, 1'b0);
      @(negedge clk); #2;
    end
    ce = 1'b1;

    // Combinational output and combinational input: zero latency
    d0 = 1'b0; #1;
    check_bit("comb_pin0", pin_comb, 1'b0);
    check_bit("comb_din0", comb_i0, 1'b0);
    d0 = 1'b1; #1;
    check_bit("comb_pin1", pin_comb, 1'b1);
    check_bit("comb_din1", comb_i0, 1'b1);

    // Registered enable: released through cycle 3, driven with q0=1 from the cycle-4 rise
    d0 = 1'b1; oe = 1'b0; ext_tri_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #2;
      check_bit("t4_released", pin_tri, 1'b0);
      @(negedge clk); #1;
      check_bit("t4_released_lo", pin_tri, 1'b0);
      #1;
    end
    oe = 1'b1; ext_tri_en = 1'b0;
    @(posedge clk); #2;
    check_bit("t4_driven", pin_tri, 1'b1);
    @(negedge clk); #1;
    check_bit("t4_driven_lo", pin_tri, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
